// File: rtl/mem_responder_if.sv
// Request/response channel between the controller/datapath and the memory responder.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accept, wait WAIT_CYCLES, access the word array,
// then pulse one response. Supports word, lb/lbu loads and word/byte stores.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CntInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept;
  logic             do_access;
  logic             acc_we;
  logic [1:0]       acc_size;
  logic [31:0]      acc_addr, acc_wdata;
  logic [AddrW-1:0] idx;
  logic [1:0]       lane;
  logic [31:0]      rd_word, wr_word;
  logic [7:0]       sel_byte;
  logic             acc_err;
  logic             mem_we;

  assign accept = bus.req_valid && bus.req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
          cnt_d   = CntInit;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.req_ready = (state_q == StIdle) && reset;
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

  // With zero wait states the access happens at the accept edge, so use live inputs there.
  always_comb begin
    if (state_q == StIdle) begin
      acc_we    = bus.req_we;
      acc_size  = bus.req_size;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_we    = we_q;
      acc_size  = size_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign do_access = ((state_q == StWait) && (cnt_q == 4'd0)) ||
                     ((state_q == StIdle) && accept && (WAIT_CYCLES == 0));

  assign idx     = acc_addr[AddrW+1:2];
  assign lane    = acc_addr[1:0];
  assign rd_word = mem_q[idx];
  assign acc_err = (|acc_addr[31:AddrW+2]) || (acc_size == 2'b11) ||
                   ((acc_size == 2'b00) && (lane != 2'b00));
  assign mem_we  = do_access && acc_we && !acc_err;

  always_comb begin
    sel_byte = rd_word[7:0];
    wr_word  = rd_word;
    unique case (lane)
      2'd0: begin sel_byte = rd_word[7:0];   wr_word[7:0]   = acc_wdata[7:0]; end
      2'd1: begin sel_byte = rd_word[15:8];  wr_word[15:8]  = acc_wdata[7:0]; end
      2'd2: begin sel_byte = rd_word[23:16]; wr_word[23:16] = acc_wdata[7:0]; end
      2'd3: begin sel_byte = rd_word[31:24]; wr_word[31:24] = acc_wdata[7:0]; end
      default: ;
    endcase
    if (acc_size == 2'b00) wr_word = acc_wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (do_access) begin
      err_d   = acc_err;
      rdata_d = 32'd0;
      if (!acc_err && !acc_we) begin
        unique case (acc_size)
          2'b00:   rdata_d = rd_word;
          2'b01:   rdata_d = {{24{sel_byte[7]}}, sel_byte};
          2'b10:   rdata_d = {24'd0, sel_byte};
          default: rdata_d = 32'd0;
        endcase
      end
    end
  end

  // Gated by reset so a reset landing on the access edge never commits a store.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem_q[idx] <= wr_word;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one 2-wait-state instance and one 0-wait-state instance.
module tb_mem_responder;

  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE after the response.
  task automatic xfer(input string tag, input logic we, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
    int lat;
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = we;
    bus_a.req_size  = size;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    check({tag, ".ready"}, 32'(bus_a.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    bus_a.req_wdata = 32'hxxxx_xxxx;
    bus_a.req_addr  = 32'hxxxx_xxxx;
    lat = 1;
    while (!bus_a.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'd3);
    rdata = bus_a.rsp_rdata;
    err   = bus_a.rsp_err;
    @(negedge clk);
    check({tag, ".pulse"}, 32'(bus_a.rsp_valid), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  bit          saw_rsp;

  initial begin
    nvec = 0;
    nerr = 0;
    reset = 1'b0;
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_size = 2'b00;
    bus_a.req_addr = 32'd0; bus_a.req_wdata = 32'd0;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_size = 2'b00;
    bus_b.req_addr = 32'd0; bus_b.req_wdata = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ready", 32'(bus_a.req_ready), 32'd0);
    check("rst.rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("rst.rdata", bus_a.rsp_rdata, 32'd0);
    check("rst.err", 32'(bus_a.rsp_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel.ready", 32'(bus_a.req_ready), 32'd1);

    // Word store/load
    xfer("st10", 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, rd, er);
    check("st10.err", 32'(er), 32'd0);
    check("st10.rdata", rd, 32'd0);
    xfer("ld10", 1'b0, 2'b00, 32'h10, 32'd0, rd, er);
    check("ld10.rdata", rd, 32'hDEADBEEF);
    check("ld10.err", 32'(er), 32'd0);

    // Byte loads
    xfer("st20", 1'b1, 2'b00, 32'h20, 32'h8000007F, rd, er);
    xfer("lb23", 1'b0, 2'b01, 32'h23, 32'd0, rd, er);
    check("lb23.rdata", rd, 32'hFFFFFF80);
    xfer("lbu23", 1'b0, 2'b10, 32'h23, 32'd0, rd, er);
    check("lbu23.rdata", rd, 32'h00000080);
    xfer("lb20", 1'b0, 2'b01, 32'h20, 32'd0, rd, er);
    check("lb20.rdata", rd, 32'h0000007F);

    // Byte store
    xfer("st40", 1'b1, 2'b00, 32'h40, 32'h11223344, rd, er);
    xfer("sb41", 1'b1, 2'b01, 32'h41, 32'hFFFFFFAA, rd, er);
    check("sb41.err", 32'(er), 32'd0);
    xfer("ld40", 1'b0, 2'b00, 32'h40, 32'd0, rd, er);
    check("ld40.rdata", rd, 32'h1122AA44);
    xfer("lbu42", 1'b0, 2'b10, 32'h42, 32'd0, rd, er);
    check("lbu42.rdata", rd, 32'h00000022);

    // Errors
    xfer("ldmis", 1'b0, 2'b00, 32'h42, 32'd0, rd, er);
    check("ldmis.err", 32'(er), 32'd1);
    check("ldmis.rdata", rd, 32'd0);
    xfer("st00", 1'b1, 2'b00, 32'h0, 32'hA5A5A5A5, rd, er);
    xfer("st100", 1'b1, 2'b00, 32'h100, 32'h5A5A5A5A, rd, er);
    check("st100.err", 32'(er), 32'd1);
    xfer("ld00", 1'b0, 2'b00, 32'h0, 32'd0, rd, er);
    check("ld00.rdata", rd, 32'hA5A5A5A5);
    check("ld00.err", 32'(er), 32'd0);
    xfer("sz11", 1'b0, 2'b11, 32'h10, 32'd0, rd, er);
    check("sz11.err", 32'(er), 32'd1);
    check("sz11.rdata", rd, 32'd0);

    // req_valid held high: accepts every 4 cycles
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = 1'b0;
    bus_a.req_size  = 2'b00;
    bus_a.req_addr  = 32'h10;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("hold.ready%0d", i), 32'(bus_a.req_ready), 32'((i % 4) == 0));
      check($sformatf("hold.rsp%0d", i), 32'(bus_a.rsp_valid), 32'((i % 4) == 3));
      if ((i % 4) == 3) check($sformatf("hold.rdata%0d", i), bus_a.rsp_rdata, 32'hDEADBEEF);
      @(negedge clk);
    end
    bus_a.req_valid = 1'b0;

    // Zero wait states: response next cycle, spacing 2
    bus_b.req_valid = 1'b1;
    bus_b.req_we    = 1'b1;
    bus_b.req_size  = 2'b00;
    bus_b.req_addr  = 32'h4;
    bus_b.req_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("w0.ready%0d", i), 32'(bus_b.req_ready), 32'((i % 2) == 0));
      check($sformatf("w0.rsp%0d", i), 32'(bus_b.rsp_valid), 32'((i % 2) == 1));
      @(negedge clk);
    end
    bus_b.req_we = 1'b0;
    @(negedge clk);
    bus_b.req_valid = 1'b0;
    check("w0.ld.rsp", 32'(bus_b.rsp_valid), 32'd1);
    check("w0.ld.rdata", bus_b.rsp_rdata, 32'hCAFEF00D);
    @(negedge clk);
    check("w0.ld.pulse", 32'(bus_b.rsp_valid), 32'd0);

    // Reset during WAIT drops the pending store
    xfer("st08", 1'b1, 2'b00, 32'h8, 32'h0, rd, er);
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = 1'b1;
    bus_a.req_size  = 2'b00;
    bus_a.req_addr  = 32'h8;
    bus_a.req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    reset = 1'b0;
    saw_rsp = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (bus_a.rsp_valid) saw_rsp = 1'b1;
      @(negedge clk);
    end
    check("rstw.norsp", 32'(saw_rsp), 32'd0);
    xfer("ld08", 1'b0, 2'b00, 32'h8, 32'd0, rd, er);
    check("ld08.rdata", rd, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
